// File: rtl/mem_cache_ctrl.sv
`default_nettype none
// ============================================================================
// mem_cache_ctrl : set-associative write-through data cache for the MEM stage
// Optional build macro: CACHE_STATS_EN (adds hit_count / miss_count outputs)
// Revision: 1.0
// ============================================================================
module mem_cache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 2,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int BASE_ADDR  = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             mem_r_en,
  input  logic                             mem_w_en,
  output logic [DATA_WIDTH-1:0]            read_data,
  output logic                             ready,
  output logic                             sram_read,
  output logic                             sram_write,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] sram_read_data,
  input  logic                             sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count
`endif
);

  localparam int OFF_W    = $clog2(LINE_WORDS);
  localparam int WS_W     = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_BITS = $clog2(SETS);
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int TAG_W    = ADDR_WIDTH - 2 - OFF_W - IDX_BITS;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W    = WAY_W;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

  typedef logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  read_data_q, read_data_d;

  logic [WAYS-1:0]        valid_q [SETS];
  logic [TAG_W-1:0]       tag_q   [SETS][WAYS];
  line_t                  line_q  [SETS][WAYS];
  logic [AGE_W-1:0]       age_q   [SETS][WAYS];
  logic [AGE_W-1:0]       age_d   [WAYS];

  logic [ADDR_WIDTH-1:0]  eff;
  logic [WS_W-1:0]        word_sel;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  line_t                  fill_line;

  logic                   hit;
  logic [WAY_W-1:0]       hit_way;
  logic [WAY_W-1:0]       victim;
  logic [WAY_W-1:0]       lru_way;
  logic [AGE_W-1:0]       lru_age;
  logic [WAY_W-1:0]       inv_way;
  logic                   inv_found;
  logic [WAY_W-1:0]       touch_way;

  logic                   fill_en, wr_en, age_en, hit_inc, miss_inc;

  assign eff       = address - ADDR_WIDTH'(BASE_ADDR);
  assign word_sel  = WS_W'((eff >> 2) & ADDR_WIDTH'(LINE_WORDS - 1));
  assign idx       = IDX_W'((eff >> (2 + OFF_W)) & ADDR_WIDTH'(SETS - 1));
  assign tag       = TAG_W'(eff >> (2 + OFF_W + IDX_BITS));
  assign fill_line = sram_read_data;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest-numbered invalid way, else oldest (lowest index on ties)
  always_comb begin
    lru_way   = '0;
    lru_age   = age_q[idx][0];
    inv_way   = '0;
    inv_found = 1'b0;
    for (int w = 1; w < WAYS; w++) begin
      if (age_q[idx][w] > lru_age) begin
        lru_age = age_q[idx][w];
        lru_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim = inv_found ? inv_way : lru_way;
  end

  // Equal ages (only left over from reset) age alongside the touched way so
  // that the resulting ages become a strict recency ordering.
  always_comb begin
    touch_way = (state_q == S_FILL) ? victim : hit_way;
    for (int w = 0; w < WAYS; w++) begin
      age_d[w] = age_q[idx][w];
      if (WAY_W'(w) == touch_way)
        age_d[w] = '0;
      else if ((age_q[idx][w] <= age_q[idx][touch_way]) && (age_q[idx][w] != AGE_MAX))
        age_d[w] = age_q[idx][w] + AGE_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    ready       = 1'b1;
    sram_read   = 1'b0;
    sram_write  = 1'b0;
    fill_en     = 1'b0;
    wr_en       = 1'b0;
    age_en      = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_w_en) begin
          ready      = 1'b0;
          sram_write = 1'b1;
          wr_en      = hit;
          state_d    = S_WRITE;
        end else if (mem_r_en) begin
          if (hit) begin
            read_data_d = line_q[idx][hit_way][word_sel];
            age_en      = 1'b1;
            hit_inc     = 1'b1;
          end else begin
            ready     = 1'b0;
            sram_read = 1'b1;
            state_d   = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (sram_ready) begin
          read_data_d = fill_line[word_sel];
          fill_en     = 1'b1;
          age_en      = 1'b1;
          miss_inc    = 1'b1;
          state_d     = S_IDLE;
        end else begin
          ready     = 1'b0;
          sram_read = 1'b1;
        end
      end
      S_WRITE: begin
        if (sram_ready) begin
          state_d = S_IDLE;
        end else begin
          ready      = 1'b0;
          sram_write = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign read_data = read_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      read_data_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
      end
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      if (fill_en) begin
        valid_q[idx][victim] <= 1'b1;
        tag_q[idx][victim]   <= tag;
        line_q[idx][victim]  <= fill_line;
      end
      if (wr_en) line_q[idx][hit_way][word_sel] <= write_data;
      if (age_en) begin
        for (int w = 0; w < WAYS; w++) age_q[idx][w] <= age_d[w];
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit_inc && (hit_count_q != 32'hFFFF_FFFF))   hit_count_d  = hit_count_q + 32'd1;
    if (miss_inc && (miss_count_q != 32'hFFFF_FFFF)) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_cache_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_cache_ctrl : directed table-driven bench for mem_cache_ctrl
// Revision: 1.0
// ============================================================================
module tb_mem_cache_ctrl;

  localparam int OP_LD   = 0;
  localparam int OP_ST   = 1;
  localparam int OP_BOTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] read_data;
  logic        ready;
  logic        sram_read;
  logic        sram_write;
  logic [63:0] sram_read_data;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  always #5 clk = ~clk;

  mem_cache_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .address        (address),
    .write_data     (write_data),
    .mem_r_en       (mem_r_en),
    .mem_w_en       (mem_w_en),
    .read_data      (read_data),
    .ready          (ready),
    .sram_read      (sram_read),
    .sram_write     (sram_write),
    .sram_read_data (sram_read_data),
    .sram_ready     (sram_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [63:0] line;
    bit          hit;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          tests  = 0;
  int          failed = 0;
  int          exp_hits = 0;
  int          exp_misses = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input int lat,
                         input logic [63:0] line, input bit hit, input logic [31:0] exp);
    @(negedge clk);
    address  = a;
    mem_r_en = 1'b1;
    #1;
    if (hit) begin
      chk({tag, " hit ready"}, ready, 1);
      chk({tag, " hit sram_read"}, sram_read, 0);
      chk({tag, " hit rdata"}, read_data, exp);
      exp_hits++;
    end else begin
      chk({tag, " miss ready"}, ready, 0);
      chk({tag, " miss sram_read"}, sram_read, 1);
      for (int c = 1; c < lat; c++) begin
        @(negedge clk); #1;
        chk({tag, " fill ready"}, ready, 0);
        chk({tag, " fill sram_read"}, sram_read, 1);
      end
      @(negedge clk);
      sram_read_data = line;
      sram_ready     = 1'b1;
      #1;
      chk({tag, " done ready"}, ready, 1);
      chk({tag, " done sram_read"}, sram_read, 0);
      chk({tag, " done rdata"}, read_data, exp);
      exp_misses++;
    end
    last_rd = exp;
    @(negedge clk);
    mem_r_en   = 1'b0;
    sram_ready = 1'b0;
    #1;
    chk({tag, " after ready"}, ready, 1);
    chk({tag, " after rdata hold"}, read_data, last_rd);
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input int lat, input bit both);
    @(negedge clk);
    address    = a;
    write_data = d;
    mem_w_en   = 1'b1;
    mem_r_en   = both;
    #1;
    chk({tag, " st ready"}, ready, 0);
    chk({tag, " st sram_write"}, sram_write, 1);
    chk({tag, " st sram_read"}, sram_read, 0);
    for (int c = 1; c < lat; c++) begin
      @(negedge clk); #1;
      chk({tag, " st wait ready"}, ready, 0);
      chk({tag, " st wait sram_write"}, sram_write, 1);
    end
    @(negedge clk);
    sram_ready = 1'b1;
    #1;
    chk({tag, " st done ready"}, ready, 1);
    @(negedge clk);
    mem_w_en   = 1'b0;
    mem_r_en   = 1'b0;
    sram_ready = 1'b0;
    #1;
    chk({tag, " st after sram_write"}, sram_write, 0);
    chk({tag, " st after ready"}, ready, 1);
    chk({tag, " st rdata hold"}, read_data, last_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Tags in set 0: A=0x400, B=0x600, C=0x800, D=0x1000 (512-byte stride)
    vecs.push_back('{OP_LD,   32'h400,  32'h0,        3, 64'hBBBB0002_AAAA0001, 1'b0, 32'hAAAA0001});
    vecs.push_back('{OP_LD,   32'h404,  32'h0,        0, 64'h0,                 1'b1, 32'hBBBB0002});
    vecs.push_back('{OP_ST,   32'h400,  32'h12345678, 2, 64'h0,                 1'b0, 32'h0});
    vecs.push_back('{OP_LD,   32'h400,  32'h0,        0, 64'h0,                 1'b1, 32'h12345678});
    vecs.push_back('{OP_LD,   32'h600,  32'h0,        1, 64'h22220002_22220001, 1'b0, 32'h22220001});
    vecs.push_back('{OP_LD,   32'h400,  32'h0,        0, 64'h0,                 1'b1, 32'h12345678});
    vecs.push_back('{OP_LD,   32'h800,  32'h0,        2, 64'h33330002_33330001, 1'b0, 32'h33330001});
    vecs.push_back('{OP_LD,   32'h404,  32'h0,        0, 64'h0,                 1'b1, 32'hBBBB0002});
    vecs.push_back('{OP_LD,   32'h604,  32'h0,        1, 64'h44440002_44440001, 1'b0, 32'h44440002});
    vecs.push_back('{OP_ST,   32'h1000, 32'hDEADBEEF, 2, 64'h0,                 1'b0, 32'h0});
    vecs.push_back('{OP_LD,   32'h1000, 32'h0,        2, 64'h55550002_55550001, 1'b0, 32'h55550001});
    vecs.push_back('{OP_LD,   32'h408,  32'h0,        1, 64'h66660002_66660001, 1'b0, 32'h66660001});
    vecs.push_back('{OP_LD,   32'h40C,  32'h0,        0, 64'h0,                 1'b1, 32'h66660002});
    vecs.push_back('{OP_BOTH, 32'h408,  32'hCAFEF00D, 3, 64'h0,                 1'b0, 32'h0});
    vecs.push_back('{OP_LD,   32'h408,  32'h0,        0, 64'h0,                 1'b1, 32'hCAFEF00D});
    vecs.push_back('{OP_LD,   32'h600,  32'h0,        0, 64'h0,                 1'b1, 32'h44440001});

    rst            = 1'b1;
    address        = '0;
    write_data     = '0;
    mem_r_en       = 1'b0;
    mem_w_en       = 1'b0;
    sram_read_data = '0;
    sram_ready     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset ready", ready, 1);
    chk("reset sram_read", sram_read, 0);
    chk("reset sram_write", sram_write, 0);
    chk("reset read_data", read_data, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].op == OP_LD)
        do_load($sformatf("v%0d", i), vecs[i].addr, vecs[i].lat, vecs[i].line, vecs[i].hit, vecs[i].exp);
      else
        do_store($sformatf("v%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].op == OP_BOTH);
    end

`ifdef CACHE_STATS_EN
    chk("hit_count", hit_count, 64'(exp_hits));
    chk("miss_count", miss_count, 64'(exp_misses));
`endif

    // Stray sram_ready while idle must not start or complete anything
    @(negedge clk);
    sram_ready = 1'b1;
    #1;
    chk("idle sram_ready ready", ready, 1);
    chk("idle sram_ready sram_read", sram_read, 0);
    chk("idle sram_ready sram_write", sram_write, 0);
    @(negedge clk);
    sram_ready = 1'b0;
    do_load("idle_ready_hit", 32'h40C, 0, 64'h0, 1'b1, 32'h66660002);

    // Reset one cycle into a fill, SRAM answer arriving afterwards
    @(negedge clk);
    address  = 32'h800;
    mem_r_en = 1'b1;
    #1;
    chk("abort req sram_read", sram_read, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort fill sram_read", sram_read, 1);
    @(negedge clk);
    rst      = 1'b0;
    mem_r_en = 1'b0;
    #1;
    chk("abort ready", ready, 1);
    chk("abort sram_read", sram_read, 0);
    chk("abort read_data", read_data, 0);
    last_rd    = '0;
    exp_hits   = 0;
    exp_misses = 0;
    @(negedge clk);
    sram_read_data = 64'h99990002_99990001;
    sram_ready     = 1'b1;
    #1;
    chk("late sram_ready ready", ready, 1);
    chk("late sram_ready sram_read", sram_read, 0);
    chk("late sram_ready read_data", read_data, 0);
    @(negedge clk);
    sram_ready = 1'b0;
    do_load("post_rst_600", 32'h600, 1, 64'h77770002_77770001, 1'b0, 32'h77770001);
    do_load("post_rst_40C", 32'h40C, 2, 64'h88880002_88880001, 1'b0, 32'h88880002);
    do_load("post_rst_hit", 32'h600, 0, 64'h0, 1'b1, 32'h77770001);

`ifdef CACHE_STATS_EN
    chk("post_rst hit_count", hit_count, 64'(exp_hits));
    chk("post_rst miss_count", miss_count, 64'(exp_misses));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_cache_ctrl.md
Name: mem_cache_ctrl

Overview:
- Parametrised set-associative, write-through data-cache controller for the MEM stage.
- Sits between the pipeline (ALU result as address, Rm value as store data) and the SRAM controller. Serves read hits in zero wait cycles and drives `ready` low to freeze the pipeline on misses and stores.
- Successor to the fixed 2-way/64-set controller: sets, ways, line size and base address are generalised, and replacement is true LRU for up to 4 ways.

Parameters:
- ADDR_WIDTH, 32, pipeline address width.
- DATA_WIDTH, 32, pipeline word width.
- LINE_WORDS, 2, words per line; power of 2; a line is the SRAM controller transfer width.
- SETS, 64, number of sets; power of 2.
- WAYS, 2, associativity; legal values 1, 2, 4.
- BASE_ADDR, 1024, offset subtracted from `address` before decode.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- address  in  ADDR_WIDTH  byte address from EX
- write_data  in  DATA_WIDTH  store data
- mem_r_en  in  1  load request
- mem_w_en  in  1  store request
- read_data  out  DATA_WIDTH  load result
- ready  out  1  request complete; low means freeze
- sram_read  out  1  line-fill request
- sram_write  out  1  word write-through request
- sram_read_data  in  LINE_WORDS*DATA_WIDTH  fill line
- sram_ready  in  1  SRAM controller done, one-cycle pulse

Behaviour:
- Decode `eff = address - BASE_ADDR`:
  - bits [1:0] are ignored.
  - Next log2(LINE_WORDS) bits give the word select.
  - Next log2(SETS) bits give the index.
  - Remaining bits give the tag.
- Storage per set, per way: valid bit, tag, line. Per set: age counter of log2(WAYS) bits per way (none when WAYS=1).
- Reset:
  - All valid bits cleared and all ages set to 0.
  - FSM goes to IDLE.
  - Outputs: sram_read=0, sram_write=0, read_data=0.
  - ready=1 (no request is pending in IDLE).
- FSM states: IDLE, FILL, WRITE.
- IDLE with no request: ready=1.
- IDLE, mem_r_en, hit:
  - ready=1 and read_data = selected word in the same cycle (combinational).
  - Ages updated at the clock edge: hit way becomes 0; ways younger than it increment.
- IDLE, mem_r_en, miss:
  - ready=0, sram_read=1, go to FILL.
- FILL:
  - sram_read held high until sram_ready.
  - In the sram_ready cycle: ready=1, read_data = word from sram_read_data (forwarded), sram_read=0.
  - At the clock edge: victim line written and marked valid with the new tag, LRU updated, return to IDLE.
- Victim selection: lowest-numbered invalid way; otherwise the way with the maximum age.
- IDLE, mem_w_en:
  - ready=0, sram_write=1, go to WRITE.
  - Write hit: cached word updated at this edge (write-update).
  - Write miss: no allocation.
- WRITE: sram_write held until sram_ready; that cycle ready=1, then return to IDLE.
- mem_r_en and mem_w_en both high: treated as a store.
- Pipeline holds address and data stable while ready=0. Inputs are re-sampled only in IDLE.
- read_data outside a load-completion cycle: holds its last value.
- sram_ready arriving in IDLE: ignored.
- rst asserted during FILL or WRITE: abort at the next edge. The partially filled line is not written; strobes drop.
- Worst-case latency: 1 + SRAM latency cycles. Hit latency: 0 wait cycles.

Optional Feature:
- Macro: CACHE_STATS_EN.
- When defined:
  - Adds outputs hit_count [31:0] and miss_count [31:0].
  - Each counts completed loads (hit in IDLE, miss on FILL completion).
  - Both counters cleared by rst and saturate at 0xFFFFFFFF.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold load 0x400 (eff 0), SRAM returns line {0xBBBB0002,0xAAAA0001} after 3 cycles -> sram_read high 3 cycles; ready low until the sram_ready cycle; read_data=0xAAAA0001; miss_count=1.
- Load 0x404 immediately after -> hit, ready=1 same cycle, read_data=0xBBBB0002, sram_read stays 0, hit_count=1.
- Store 0x12345678 to 0x400, then load 0x400 -> sram_write pulse held until sram_ready; following load hits with 0x12345678.
- WAYS=2, SETS=64, LINE_WORDS=2: fill tags A, B into set 0; touch A; load tag C into set 0 -> B evicted; reload A hits; reload B misses.
- Store to an uncached address, then load it -> store causes no allocation; load misses and fills.
- rst asserted 1 cycle into a FILL, with sram_ready arriving later -> after reset ready=1, sram_read=0; prior hits now miss (valid bits cleared).
